// File: rtl/pn_seq_checker_if.sv
// Stream and status bundle between a PN7 bit source and pn_seq_checker.
// The master drives the sliced bit stream and the counter clear; the slave
// (the checker) returns lock status, the error pulse and the BER counters.
interface pn_seq_checker_if #(
    parameter int CNT_W = 16
);
    logic             din;
    logic             din_valid;
    logic             clr_cnt;
    logic             locked;
    logic             bit_err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [1:0]       state;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, bit_err, err_cnt, bit_cnt, state
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, bit_err, err_cnt, bit_cnt, state
    );
endinterface

// File: rtl/pn_seq_checker.sv
// PN7 (x^7+x^4+x^3+x^2+1) receive checker: self-synchronises on the incoming
// stream, confirms the lock with LOCK_THRESH correct predictions, then
// flywheels a local replica and counts bit errors for BER measurement.
// Excessive errors inside one observation window drop lock for re-acquisition.
// The interface instance must be built with the same CNT_W as this module.
module pn_seq_checker #(
    parameter int LOCK_THRESH = 16,
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    pn_seq_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;

    logic [7:1]       h;
    logic [7:1]       h_nxt;
    logic [2:0]       fill_cnt;
    logic [2:0]       fill_nxt;
    logic [7:0]       good_cnt;
    logic [7:0]       good_nxt;
    logic [15:0]      win_cnt;
    logic [15:0]      win_nxt;
    logic [15:0]      win_err;
    logic [15:0]      werr_nxt;

    logic             bit_err_q;
    logic             bit_err_nxt;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_nxt;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_nxt;

    logic             pred;
    logic             mis;
    logic             lock_bit;

    // h[1] is the newest bit, so h[j] is d(k-j) for the bit about to arrive
    assign pred     = h[7] ^ h[4] ^ h[3] ^ h[2];
    assign mis      = bus.din ^ pred;
    assign lock_bit = bus.din_valid && (cur_state == LOCKED);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= SEARCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and acquisition/window bookkeeping; only valid bits move anything
    always_comb begin
        nxt_state = cur_state;
        h_nxt     = h;
        fill_nxt  = fill_cnt;
        good_nxt  = good_cnt;
        win_nxt   = win_cnt;
        werr_nxt  = win_err;
        if (bus.din_valid) begin
            case (cur_state)
                SEARCH: begin
                    h_nxt    = {h[6:1], bus.din};
                    fill_nxt = (fill_cnt == 3'd7) ? 3'd7 : fill_cnt + 3'd1;
                    if (fill_nxt == 3'd7 && h_nxt != 7'd0) begin
                        nxt_state = VERIFY;
                        good_nxt  = 8'd0;
                    end
                end
                VERIFY: begin
                    h_nxt = {h[6:1], bus.din};
                    if (mis) begin
                        nxt_state = SEARCH;
                        fill_nxt  = 3'd0;
                        good_nxt  = 8'd0;
                    end else begin
                        good_nxt = good_cnt + 8'd1;
                        if (good_nxt == 8'(LOCK_THRESH)) begin
                            nxt_state = LOCKED;
                            win_nxt   = 16'd0;
                            werr_nxt  = 16'd0;
                        end
                    end
                end
                LOCKED: begin
                    h_nxt    = {h[6:1], pred};
                    werr_nxt = win_err + {15'd0, mis};
                    if (mis && werr_nxt == 16'(LOSS_THRESH)) begin
                        nxt_state = SEARCH;
                        fill_nxt  = 3'd0;
                    end else if (win_cnt == 16'(WIN_LEN - 1)) begin
                        win_nxt  = 16'd0;
                        werr_nxt = 16'd0;
                    end else begin
                        win_nxt = win_cnt + 16'd1;
                    end
                end
                default: begin
                    nxt_state = SEARCH;
                    fill_nxt  = 3'd0;
                end
            endcase
        end
    end

    // Output next values: error pulse and saturating counters, clear wins over increment
    always_comb begin
        bit_err_nxt = lock_bit && mis;
        err_cnt_nxt = err_cnt_q;
        bit_cnt_nxt = bit_cnt_q;
        if (bus.clr_cnt) begin
            err_cnt_nxt = '0;
            bit_cnt_nxt = '0;
        end else begin
            if (bit_err_nxt && err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_nxt = err_cnt_q + CNT_W'(1);
            end
            if (lock_bit && bit_cnt_q != {CNT_W{1'b1}}) begin
                bit_cnt_nxt = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h         <= 7'd0;
            fill_cnt  <= 3'd0;
            good_cnt  <= 8'd0;
            win_cnt   <= 16'd0;
            win_err   <= 16'd0;
            bit_err_q <= 1'b0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            h         <= h_nxt;
            fill_cnt  <= fill_nxt;
            good_cnt  <= good_nxt;
            win_cnt   <= win_nxt;
            win_err   <= werr_nxt;
            bit_err_q <= bit_err_nxt;
            err_cnt_q <= err_cnt_nxt;
            bit_cnt_q <= bit_cnt_nxt;
        end
    end

    assign bus.locked  = (cur_state == LOCKED);
    assign bus.state   = cur_state;
    assign bus.bit_err = bit_err_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_pn_seq_checker.sv
// Directed bench for pn_seq_checker: a reference PN7 generator feeds the
// checker, selected bits are inverted, and each scenario task checks the
// lock timing, error pulse and counters against hand-computed values.
module tb_pn_seq_checker;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    logic [7:1] g;

    pn_seq_checker_if #(.CNT_W(16)) bus ();

    pn_seq_checker #(
        .LOCK_THRESH(16),
        .WIN_LEN(64),
        .LOSS_THRESH(8),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_ref_bit(output logic b);
        b = g[7] ^ g[4] ^ g[3] ^ g[2];
        g = {g[6:1], b};
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.clr_cnt   = 1'b0;
        g             = 7'h01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One valid bit from the reference, optionally inverted; outputs sampled #1 after the edge
    task automatic send_bit(input logic flip, input logic clr);
        logic b;
        next_ref_bit(b);
        @(negedge clk);
        bus.din       = b ^ flip;
        bus.din_valid = 1'b1;
        bus.clr_cnt   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send_zero();
        @(negedge clk);
        bus.din       = 1'b0;
        bus.din_valid = 1'b1;
        bus.clr_cnt   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.din       = ~bus.din;
        bus.din_valid = 1'b0;
        bus.clr_cnt   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.state !== 2'd0) begin failures++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state); end
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked: got %0b expected 0", bus.locked); end
        checks++; if (bus.bit_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_bit_err: got %0b expected 0", bus.bit_err); end
        checks++; if (bus.err_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", bus.err_cnt); end
        checks++; if (bus.bit_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_bit_cnt: got %0d expected 0", bus.bit_cnt); end
    endtask

    task automatic test_acquire();
        int err_seen;
        err_seen = 0;
        do_reset();
        send_clean(6);
        checks++; if (bus.state !== 2'd0) begin failures++; $display("[TB] FAIL acq_state_bit6: got %0d expected 0", bus.state); end
        send_clean(1);
        checks++; if (bus.state !== 2'd1) begin failures++; $display("[TB] FAIL acq_state_bit7: got %0d expected 1", bus.state); end
        send_clean(15);
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("[TB] FAIL acq_locked_bit22: got %0b expected 0", bus.locked); end
        send_clean(1);
        checks++; if (bus.locked !== 1'b1) begin failures++; $display("[TB] FAIL acq_locked_bit23: got %0b expected 1", bus.locked); end
        checks++; if (bus.state !== 2'd2) begin failures++; $display("[TB] FAIL acq_state_bit23: got %0d expected 2", bus.state); end
        for (int i = 24; i <= 1000; i++) begin
            send_bit(1'b0, 1'b0);
            if (bus.bit_err !== 1'b0) err_seen++;
        end
        checks++; if (err_seen !== 0) begin failures++; $display("[TB] FAIL acq_bit_err_pulses: got %0d expected 0", err_seen); end
        checks++; if (bus.err_cnt !== 16'd0) begin failures++; $display("[TB] FAIL acq_err_cnt: got %0d expected 0", bus.err_cnt); end
        checks++; if (bus.bit_cnt !== 16'd977) begin failures++; $display("[TB] FAIL acq_bit_cnt: got %0d expected 977", bus.bit_cnt); end
    endtask

    task automatic test_zero_stream();
        int bad_state;
        bad_state = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_zero();
            if (bus.state !== 2'd0) bad_state++;
        end
        checks++; if (bad_state !== 0) begin failures++; $display("[TB] FAIL zero_state_left_search: got %0d expected 0", bad_state); end
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("[TB] FAIL zero_locked: got %0b expected 0", bus.locked); end
        checks++; if (bus.err_cnt !== 16'd0 || bus.bit_cnt !== 16'd0) begin failures++; $display("[TB] FAIL zero_counters: got %0d/%0d expected 0/0", bus.err_cnt, bus.bit_cnt); end
    endtask

    task automatic test_single_error();
        int err_seen;
        err_seen = 0;
        do_reset();
        send_clean(100);
        send_bit(1'b1, 1'b0);
        checks++; if (bus.bit_err !== 1'b1) begin failures++; $display("[TB] FAIL single_bit_err: got %0b expected 1", bus.bit_err); end
        checks++; if (bus.err_cnt !== 16'd1) begin failures++; $display("[TB] FAIL single_err_cnt: got %0d expected 1", bus.err_cnt); end
        checks++; if (bus.locked !== 1'b1) begin failures++; $display("[TB] FAIL single_locked: got %0b expected 1", bus.locked); end
        for (int i = 0; i < 200; i++) begin
            send_bit(1'b0, 1'b0);
            if (bus.bit_err !== 1'b0) err_seen++;
        end
        checks++; if (err_seen !== 0) begin failures++; $display("[TB] FAIL single_later_pulses: got %0d expected 0", err_seen); end
        checks++; if (bus.err_cnt !== 16'd1) begin failures++; $display("[TB] FAIL single_err_cnt_after: got %0d expected 1", bus.err_cnt); end
        checks++; if (bus.bit_cnt !== 16'd278) begin failures++; $display("[TB] FAIL single_bit_cnt: got %0d expected 278", bus.bit_cnt); end
        checks++; if (bus.locked !== 1'b1) begin failures++; $display("[TB] FAIL single_locked_after: got %0b expected 1", bus.locked); end
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        send_clean(30);
        for (int i = 0; i <= 35; i++) begin
            send_bit((i % 5) == 0, 1'b0);
            if (i == 30) begin
                checks++; if (bus.locked !== 1'b1) begin failures++; $display("[TB] FAIL loss_locked_after7: got %0b expected 1", bus.locked); end
            end
        end
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("[TB] FAIL loss_locked_after8: got %0b expected 0", bus.locked); end
        checks++; if (bus.state !== 2'd0) begin failures++; $display("[TB] FAIL loss_state: got %0d expected 0", bus.state); end
        checks++; if (bus.bit_err !== 1'b1) begin failures++; $display("[TB] FAIL loss_bit_err: got %0b expected 1", bus.bit_err); end
        checks++; if (bus.err_cnt !== 16'd8) begin failures++; $display("[TB] FAIL loss_err_cnt: got %0d expected 8", bus.err_cnt); end
        send_clean(22);
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("[TB] FAIL reacq_locked_22: got %0b expected 0", bus.locked); end
        send_clean(1);
        checks++; if (bus.locked !== 1'b1) begin failures++; $display("[TB] FAIL reacq_locked_23: got %0b expected 1", bus.locked); end
        checks++; if (bus.err_cnt !== 16'd8) begin failures++; $display("[TB] FAIL reacq_err_cnt_held: got %0d expected 8", bus.err_cnt); end
    endtask

    task automatic test_verify_error_and_window();
        logic flip;
        do_reset();
        send_clean(17);
        checks++; if (bus.state !== 2'd1) begin failures++; $display("[TB] FAIL verr_state_before: got %0d expected 1", bus.state); end
        send_bit(1'b1, 1'b0);
        checks++; if (bus.state !== 2'd0) begin failures++; $display("[TB] FAIL verr_state_after: got %0d expected 0", bus.state); end
        checks++; if (bus.bit_err !== 1'b0) begin failures++; $display("[TB] FAIL verr_bit_err: got %0b expected 0", bus.bit_err); end
        send_clean(22);
        checks++; if (bus.locked !== 1'b0) begin failures++; $display("[TB] FAIL verr_locked_22: got %0b expected 0", bus.locked); end
        send_clean(1);
        checks++; if (bus.locked !== 1'b1) begin failures++; $display("[TB] FAIL verr_locked_23: got %0b expected 1", bus.locked); end
        checks++; if (bus.err_cnt !== 16'd0) begin failures++; $display("[TB] FAIL verr_err_cnt: got %0d expected 0", bus.err_cnt); end
        // Seven errors in the first window, seven in the next: the wrap must keep lock
        for (int k = 1; k <= 130; k++) begin
            flip = ((k % 5) == 0) && ((k >= 5 && k <= 35) || (k >= 70 && k <= 100));
            send_bit(flip, 1'b0);
            if (k == 35) begin
                checks++; if (bus.locked !== 1'b1) begin failures++; $display("[TB] FAIL win_locked_first7: got %0b expected 1", bus.locked); end
            end
        end
        checks++; if (bus.locked !== 1'b1) begin failures++; $display("[TB] FAIL win_locked_end: got %0b expected 1", bus.locked); end
        checks++; if (bus.err_cnt !== 16'd14) begin failures++; $display("[TB] FAIL win_err_cnt: got %0d expected 14", bus.err_cnt); end
    endtask

    task automatic test_valid_toggle_clr_reset();
        int err_seen;
        err_seen = 0;
        do_reset();
        send_clean(30);
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0, 1'b0);
            idle_cycle();
            if (bus.bit_err !== 1'b0) err_seen++;
        end
        checks++; if (bus.bit_cnt !== 16'd27) begin failures++; $display("[TB] FAIL toggle_bit_cnt: got %0d expected 27", bus.bit_cnt); end
        checks++; if (err_seen !== 0) begin failures++; $display("[TB] FAIL toggle_idle_pulses: got %0d expected 0", err_seen); end
        send_bit(1'b1, 1'b1);
        checks++; if (bus.err_cnt !== 16'd0 || bus.bit_cnt !== 16'd0) begin failures++; $display("[TB] FAIL clr_counters: got %0d/%0d expected 0/0", bus.err_cnt, bus.bit_cnt); end
        checks++; if (bus.bit_err !== 1'b1) begin failures++; $display("[TB] FAIL clr_bit_err: got %0b expected 1", bus.bit_err); end
        send_bit(1'b1, 1'b0);
        checks++; if (bus.err_cnt !== 16'd1 || bus.bit_cnt !== 16'd1) begin failures++; $display("[TB] FAIL post_clr_counters: got %0d/%0d expected 1/1", bus.err_cnt, bus.bit_cnt); end
        // Mid-cycle reset must clear outputs without waiting for a clock edge
        reset_n = 1'b0;
        #1;
        checks++; if (bus.locked !== 1'b0 || bus.state !== 2'd0) begin failures++; $display("[TB] FAIL async_state: got locked=%0b state=%0d expected 0/0", bus.locked, bus.state); end
        checks++; if (bus.bit_err !== 1'b0) begin failures++; $display("[TB] FAIL async_bit_err: got %0b expected 0", bus.bit_err); end
        checks++; if (bus.err_cnt !== 16'd0 || bus.bit_cnt !== 16'd0) begin failures++; $display("[TB] FAIL async_counters: got %0d/%0d expected 0/0", bus.err_cnt, bus.bit_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Scenario sequence and summary
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_acquire();
        test_zero_stream();
        test_single_error();
        test_loss_of_lock();
        test_verify_error_and_window();
        test_valid_toggle_clr_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
